// File: rtl/fir_output_requant.sv
// -----------------------------------------------------------------------------
// fir_output_requant
//
// Back-end stage of the FIR datapath. Takes the wide signed accumulator word,
// optionally rounds half up, drops SHIFT fraction bits with an arithmetic right
// shift, and saturates to DATA_OUT_WIDTH. Results go into a small FIFO and are
// offered downstream over valid/ready. The filter side cannot be stalled, so a
// sample arriving at a full FIFO is discarded and counted.
//
// Compile-time option:
//   FIR_OUT_ROUND_EN  defined     -> round half up (add 2^(SHIFT-1) before shift)
//                     not defined -> truncate toward minus infinity
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_data carries a new accumulator word this cycle
//   in_data    signed accumulator word, DATA_IN_WIDTH bits
//   out_valid  FIFO head is valid
//   out_ready  downstream accepts the head this cycle
//   out_data   signed requantized sample at the FIFO head (0 while empty)
//   sat_count  number of saturated samples, sticks at all-ones
//   drop_count number of samples lost to a full FIFO, sticks at all-ones
// -----------------------------------------------------------------------------
module fir_output_requant #(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int SHIFT          = 23,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DATA_IN_WIDTH-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_OUT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]      sat_count,
    output logic [CNT_WIDTH-1:0]      drop_count
);

    localparam int DIW = DATA_IN_WIDTH;
    localparam int DOW = DATA_OUT_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);

    // Saturation limits expressed in the widened (DIW+1 bit) domain.
    localparam logic signed [DIW:0] SAT_HI = {{(DIW+2-DOW){1'b0}}, {(DOW-1){1'b1}}};
    localparam logic signed [DIW:0] SAT_LO = {{(DIW+2-DOW){1'b1}}, {(DOW-1){1'b0}}};
    localparam logic [DOW-1:0]      OUT_MAX = {1'b0, {(DOW-1){1'b1}}};
    localparam logic [DOW-1:0]      OUT_MIN = {1'b1, {(DOW-1){1'b0}}};
    localparam logic [AW:0]         DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Stage 1: rounding add, one extra bit so the add can never wrap.
    // ------------------------------------------------------------------
    logic signed [DIW:0] in_ext;
    logic signed [DIW:0] r1_next;
    logic signed [DIW:0] r1_reg;
    logic                v1_reg;

    assign in_ext = {in_data[DIW-1], in_data};

`ifdef FIR_OUT_ROUND_EN
    localparam logic [DIW:0]        RC_ONE = (DIW+1)'(1);
    localparam logic signed [DIW:0] RC     = RC_ONE << (SHIFT-1);
    assign r1_next = in_ext + RC;
`else
    // Truncation: no adder, but the register stays so latency is unchanged.
    assign r1_next = in_ext;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg <= 1'b0;
            r1_reg <= '0;
        end else begin
            v1_reg <= in_valid;
            if (in_valid) begin
                r1_reg <= r1_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: arithmetic shift and saturate.
    // ------------------------------------------------------------------
    logic signed [DIW:0] q;
    logic [DOW-1:0]      s2_next;
    logic                sat_hit;
    logic [DOW-1:0]      s2_reg;
    logic                v2_reg;
    logic [CNT_WIDTH-1:0] sat_count_reg;

    assign q = r1_reg >>> SHIFT;

    always_comb begin
        s2_next = q[DOW-1:0];
        sat_hit = 1'b0;
        if (q > SAT_HI) begin
            s2_next = OUT_MAX;
            sat_hit = 1'b1;
        end else if (q < SAT_LO) begin
            s2_next = OUT_MIN;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2_reg        <= 1'b0;
            s2_reg        <= '0;
            sat_count_reg <= '0;
        end else begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                s2_reg <= s2_next;
            end
            // Counted as the saturated sample enters the stage-2 register,
            // whether or not the FIFO later accepts it.
            if (v1_reg && sat_hit && sat_count_reg != CNT_MAX) begin
                sat_count_reg <= sat_count_reg + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. A write into a full FIFO is still accepted when the head
    // is being read in the same cycle.
    // ------------------------------------------------------------------
    logic [DOW-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic [CNT_WIDTH-1:0] drop_count_reg;
    logic                 fifo_full;
    logic                 do_read;
    logic                 do_write;
    logic                 do_drop;

    assign out_valid = (count_reg != '0);
    assign fifo_full = (count_reg == DEPTH_CNT);
    assign do_read   = out_valid && out_ready;
    assign do_write  = v2_reg && (!fifo_full || do_read);
    assign do_drop   = v2_reg && fifo_full && !do_read;

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (do_write && wr_ptr_reg == AW'(gi)) begin
                    mem[gi] <= s2_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            drop_count_reg <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_read) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_write, do_read})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (do_drop && drop_count_reg != CNT_MAX) begin
                drop_count_reg <= drop_count_reg + CNT_WIDTH'(1);
            end
        end
    end

    // Memory is never cleared; masking the head keeps out_data at 0 while empty.
    assign out_data   = out_valid ? mem[rd_ptr_reg] : '0;
    assign sat_count  = sat_count_reg;
    assign drop_count = drop_count_reg;

endmodule
